// File: rtl/reaction_ctrl.sv
// Reaction-time game controller: random wait, go lamp, BCD reaction
// count in 10 ms ticks, false-start detection and 99-tick timeout.
module reaction_ctrl #(
   parameter int unsigned TICK_DIV       = 1_000_000,
   parameter int unsigned MIN_WAIT_TICKS = 100,
   parameter logic [7:0]  RAND_MASK      = 8'h7F
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       btn,
   output logic       led_go,
   output logic       false_start,
   output logic [3:0] digit_1,
   output logic [3:0] digit_2
);

   localparam int unsigned DW =
      (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
   localparam int unsigned WW =
      $clog2(MIN_WAIT_TICKS + 256) + 1;
   localparam logic [DW-1:0] DIV_LAST = DW'(TICK_DIV - 1);
   localparam logic [WW-1:0] MIN_W    = WW'(MIN_WAIT_TICKS);
   localparam logic [3:0]    BLANK    = 4'd10;

   typedef enum logic [2:0] {
      S_IDLE,
      S_WAIT,
      S_GO,
      S_SHOW,
      S_EARLY
   } state_t;

   state_t        state_q, state_d;
   logic          btn_q, btn_d;
   logic [DW-1:0] div_q, div_d;
   logic [7:0]    lfsr_q, lfsr_d;
   logic [WW-1:0] rem_q, rem_d;
   logic          led_go_q, led_go_d;
   logic          false_start_q, false_start_d;
   logic [3:0]    digit_1_q, digit_1_d;
   logic [3:0]    digit_2_q, digit_2_d;

   logic press;
   logic tick;

   assign press = btn & ~btn_q;
   assign tick  = (div_q == DIV_LAST);

   assign led_go      = led_go_q;
   assign false_start = false_start_q;
   assign digit_1     = digit_1_q;
   assign digit_2     = digit_2_q;

   // State and output registers with synchronous active-low reset
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q       <= S_IDLE;
         btn_q         <= 1'b0;
         div_q         <= '0;
         lfsr_q        <= 8'h01;
         rem_q         <= '0;
         led_go_q      <= 1'b0;
         false_start_q <= 1'b0;
         digit_1_q     <= BLANK;
         digit_2_q     <= BLANK;
      end else begin
         state_q       <= state_d;
         btn_q         <= btn_d;
         div_q         <= div_d;
         lfsr_q        <= lfsr_d;
         rem_q         <= rem_d;
         led_go_q      <= led_go_d;
         false_start_q <= false_start_d;
         digit_1_q     <= digit_1_d;
         digit_2_q     <= digit_2_d;
      end
   end

   // Edge detector delay and free-running LFSR (taps 8,6,5,4)
   always_comb begin
      btn_d  = btn;
      lfsr_d = {lfsr_q[6:0],
                lfsr_q[7] ^ lfsr_q[5] ^ lfsr_q[4] ^ lfsr_q[3]};
   end

   // Next-state, tick divider, wait countdown and display digits
   always_comb begin
      state_d       = state_q;
      div_d         = tick ? '0 : div_q + 1'b1;
      rem_d         = rem_q;
      led_go_d      = led_go_q;
      false_start_d = false_start_q;
      digit_1_d     = digit_1_q;
      digit_2_d     = digit_2_q;

      unique case (state_q)
         S_IDLE, S_SHOW, S_EARLY: begin
            if (press) begin
               state_d       = S_WAIT;
               div_d         = '0;
               rem_d         = MIN_W + WW'(lfsr_q & RAND_MASK);
               led_go_d      = 1'b0;
               false_start_d = 1'b0;
               digit_1_d     = BLANK;
               digit_2_d     = BLANK;
            end
         end
         S_WAIT: begin
            if (press) begin
               state_d       = S_EARLY;
               false_start_d = 1'b1;
               led_go_d      = 1'b0;
               digit_1_d     = 4'd0;
               digit_2_d     = 4'd0;
            end else if (tick) begin
               if (rem_q <= WW'(1)) begin
                  state_d   = S_GO;
                  div_d     = '0;
                  led_go_d  = 1'b1;
                  digit_1_d = 4'd0;
                  digit_2_d = 4'd0;
               end else begin
                  rem_d = rem_q - 1'b1;
               end
            end
         end
         S_GO: begin
            if (press) begin
               state_d  = S_SHOW;
               led_go_d = 1'b0;
            end else if (tick) begin
               if (digit_1_q == 4'd9 && digit_2_q == 4'd9) begin
                  state_d  = S_SHOW;
                  led_go_d = 1'b0;
               end else if (digit_2_q == 4'd9) begin
                  digit_2_d = 4'd0;
                  digit_1_d = digit_1_q + 4'd1;
               end else begin
                  digit_2_d = digit_2_q + 4'd1;
               end
            end
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

endmodule

// File: tb/tb_reaction_ctrl.sv
// Bench for reaction_ctrl: vector table, directed round/timeout/reset
// sequences, then random button activity against an event-time model.
module tb_reaction_ctrl;

   localparam int TD   = 4;
   localparam int MINW = 3;

   logic       clk;
   logic       rst_n;
   logic       btn;
   logic       led_go;
   logic       false_start;
   logic [3:0] digit_1;
   logic [3:0] digit_2;

   int n_cmp = 0;
   int n_bad = 0;

   reaction_ctrl #(
      .TICK_DIV(TD),
      .MIN_WAIT_TICKS(MINW),
      .RAND_MASK(8'h00)
   ) dut (
      .clk(clk),
      .rst_n(rst_n),
      .btn(btn),
      .led_go(led_go),
      .false_start(false_start),
      .digit_1(digit_1),
      .digit_2(digit_2)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Reference model: phases timed by elapsed edges since entry
   localparam int M_IDLE  = 0;
   localparam int M_WAIT  = 1;
   localparam int M_GO    = 2;
   localparam int M_SHOW  = 3;
   localparam int M_EARLY = 4;

   int m_mode = M_IDLE;
   int m_e    = 0;
   bit m_prev = 0;
   bit m_led  = 0;
   bit m_fs   = 0;
   int m_d1   = 10;
   int m_d2   = 10;

   task automatic model(input bit r, input bit b);
      bit p;
      int c;
      if (!r) begin
         m_mode = M_IDLE;
         m_prev = 0;
         m_led  = 0;
         m_fs   = 0;
         m_d1   = 10;
         m_d2   = 10;
         return;
      end
      p      = b && !m_prev;
      m_prev = b;
      if (m_mode == M_WAIT) begin
         if (p) begin
            m_mode = M_EARLY;
            m_fs   = 1;
            m_d1   = 0;
            m_d2   = 0;
         end else begin
            m_e++;
            if (m_e == MINW * TD) begin
               m_mode = M_GO;
               m_e    = 0;
               m_led  = 1;
               m_d1   = 0;
               m_d2   = 0;
            end
         end
      end else if (m_mode == M_GO) begin
         if (p) begin
            m_mode = M_SHOW;
            m_led  = 0;
         end else begin
            m_e++;
            if (m_e == 100 * TD) begin
               m_mode = M_SHOW;
               m_led  = 0;
            end else begin
               c    = m_e / TD;
               m_d1 = c / 10;
               m_d2 = c % 10;
            end
         end
      end else if (p) begin
         m_mode = M_WAIT;
         m_e    = 0;
         m_led  = 0;
         m_fs   = 0;
         m_d1   = 10;
         m_d2   = 10;
      end
   endtask

   task automatic step(input bit r, input bit b);
      rst_n = r;
      btn   = b;
      @(posedge clk);
      #1;
      model(r, b);
   endtask

   task automatic chk_out(input string name, input bit l,
                          input bit f, input int d1, input int d2);
      logic [9:0] act;
      logic [9:0] exp;
      act = {led_go, false_start, digit_1, digit_2};
      exp = {l, f, 4'(d1), 4'(d2)};
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got led=%b fs=%b d=%0d/%0d need led=%b fs=%b d=%0d/%0d",
                  name, led_go, false_start, digit_1, digit_2,
                  l, f, d1, d2);
      end
   endtask

   task automatic chk_bit(input string name, input bit act,
                          input bit exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %b need %b", name, act, exp);
      end
   endtask

   typedef struct {
      bit    r;
      bit    b;
      bit    l;
      bit    f;
      int    d1;
      int    d2;
      string name;
   } vec_t;

   vec_t vq[$];

   task automatic add(input int n, input bit r, input bit b,
                      input bit l, input bit f, input int d1,
                      input int d2, input string name);
      vec_t v;
      v.r = r; v.b = b; v.l = l; v.f = f;
      v.d1 = d1; v.d2 = d2; v.name = name;
      for (int i = 0; i < n; i++) vq.push_back(v);
   endtask

   initial begin
      rst_n = 1'b0;
      btn   = 1'b0;

      add(3,  0, 0, 0, 0, 10, 10, "reset");
      add(1,  1, 0, 0, 0, 10, 10, "idle");
      add(1,  1, 1, 0, 0, 10, 10, "wait_entry");
      add(4,  1, 0, 0, 0, 10, 10, "waiting");
      add(1,  1, 1, 0, 1, 0,  0,  "early");
      add(2,  1, 1, 0, 1, 0,  0,  "early_held");
      add(12, 1, 0, 0, 1, 0,  0,  "early_no_go");
      add(1,  1, 1, 0, 0, 10, 10, "rearm");
      add(3,  1, 0, 0, 0, 10, 10, "rearm_wait");

      foreach (vq[i]) begin
         step(vq[i].r, vq[i].b);
         chk_out(vq[i].name, vq[i].l, vq[i].f, vq[i].d1, vq[i].d2);
      end

      // Normal round
      step(0, 0);
      step(1, 0);
      step(1, 1);
      for (int k = 1; k <= 12; k++) begin
         step(1, 0);
         chk_bit("wait_led", led_go, k == 12);
      end
      chk_out("go_entry", 1, 0, 0, 0);
      for (int k = 1; k <= 20; k++) step(1, 0);
      chk_out("go_count", 1, 0, 0, 5);
      step(1, 1);
      chk_out("show_frozen", 0, 0, 0, 5);
      repeat (5) step(1, 0);
      chk_out("show_hold", 0, 0, 0, 5);

      // Timeout
      step(1, 1);
      chk_out("rearm2", 0, 0, 10, 10);
      repeat (12) step(1, 0);
      chk_out("go2", 1, 0, 0, 0);
      for (int k = 1; k <= 400; k++) begin
         step(1, 0);
         if (k == 396 || k == 399) chk_out("at_99", 1, 0, 9, 9);
         if (k == 400) chk_out("timeout", 0, 0, 9, 9);
      end
      for (int k = 0; k < 100; k++) begin
         step(1, 0);
         chk_out("timeout_hold", 0, 0, 9, 9);
      end

      // Reset in the middle of GO
      step(1, 1);
      repeat (12) step(1, 0);
      repeat (28) step(1, 0);
      chk_out("go_07", 1, 0, 0, 7);
      step(0, 0);
      chk_out("rst_mid_go", 0, 0, 10, 10);
      repeat (15) step(1, 0);
      chk_out("idle_after_rst", 0, 0, 10, 10);

      // Held button from IDLE
      step(1, 1);
      for (int k = 1; k <= 20; k++) begin
         step(1, 1);
         chk_bit("held_no_early", false_start, 1'b0);
         if (k == 12) chk_bit("held_go", led_go, 1'b1);
      end
      chk_out("held_count", 1, 0, 0, 2);

      // Button already high when reset releases
      step(0, 1);
      step(0, 1);
      chk_out("rst_btn_high", 0, 0, 10, 10);
      step(1, 1);
      for (int k = 1; k <= 12; k++) begin
         step(1, 1);
         chk_bit("rel_press_led", led_go, k == 12);
      end

      // Random activity against the model
      step(0, 0);
      for (int c = 0; c < 6000; c++) begin
         bit r;
         bit b;
         r = ($urandom_range(0, 799) != 0);
         b = ($urandom_range(0, 29) == 0) ? !btn : btn;
         step(r, b);
         n_cmp++;
         if ({led_go, false_start, digit_1, digit_2} !==
             {m_led, m_fs, 4'(m_d1), 4'(m_d2)}) begin
            n_bad++;
            $display("FAIL rand cyc %0d: got %b %b %0d/%0d need %b %b %0d/%0d",
                     c, led_go, false_start, digit_1, digit_2,
                     m_led, m_fs, m_d1, m_d2);
         end
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***",
               n_cmp, n_bad);
      $finish;
   end

endmodule
